mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the CPU's single byte-wide RAM port between three requesters: the ROB committing stores, the load buffer, and instruction fetch. Each granted access is sequenced as a byte-serial little-endian burst of 1, 2 or 4 bytes, and completion is signalled back with a one-cycle done pulse. The block also handles misprediction flushes.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on RAM and requester ports.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global enable; when 0, all state and outputs hold.
- rob_rst_in  input  1  flush from ROB (misprediction/JALR).
- rob_en_in  input  1  store request, held until rob_done_out.
- rob_addr_in  input  ADDR_WIDTH  store address.
- rob_width_in  input  3  store width: 001=1 B, 010=2 B, other=4 B.
- rob_data_in  input  32  store data, low bytes used.
- rob_done_out  output  1  store finished, 1-cycle pulse.
- lb_en_in  input  1  load request, held until lb_done_out.
- lb_addr_in  input  ADDR_WIDTH  load address.
- lb_width_in  input  3  load width, same encoding.
- lb_done_out  output  1  load finished, 1-cycle pulse.
- lb_data_out  output  32  load bytes, zero-extended; the load buffer sign-extends.
- if_en_in  input  1  fetch request, held until if_done_out.
- if_addr_in  input  ADDR_WIDTH  fetch address; always 4 bytes.
- if_done_out  output  1  fetch finished, 1-cycle pulse.
- if_data_out  output  32  instruction word.
- mem_din  input  8  RAM read data, valid the cycle after the address.
- mem_dout  output  8  RAM write data.
- mem_a  output  ADDR_WIDTH  RAM address.
- mem_wr  output  1  RAM write strobe (1 = write).
- io_buffer_full  input  1  UART buffer full.

## Operation
- States: IDLE, READ, WRITE. The grant owner is latched as STORE, LOAD or FETCH.
- Grant happens in IDLE only. Fixed priority: STORE > LOAD > FETCH.
- On grant the block latches addr, width, data and owner, and sets byte count nbytes (1/2/4) and cnt=0.
- WRITE:
  - Drives mem_a=addr+cnt, mem_dout=data[8*cnt+7:8*cnt], mem_wr=1 for one cycle per byte.
  - After the last byte: mem_wr<=0, rob_done_out<=1, state IDLE.
- READ:
  - Drives mem_a=addr+cnt and mem_wr=0.
  - On the following edge, captures mem_din into byte cnt of the buffer.
  - After capturing byte nbytes-1: pulses done for the owner, drives the owner's data output with the buffer (upper bytes 0), state IDLE.
- IO stall: a write with addr[17:16]==2'b11 is not granted while io_buffer_full=1. Lower-priority requests are not granted in its place; the arbiter waits.
- Flush (rob_rst_in=1 at an edge):
  - If in READ for LOAD or FETCH: abort, state IDLE, mem_a<=0, no done pulse.
  - LOAD/FETCH requests present at the same edge are not granted.
  - An in-flight WRITE continues; a STORE request at that edge is granted, because stores are already committed.
- Address arithmetic: addr+cnt is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values (asynchronous): state IDLE; mem_a=0, mem_dout=0, mem_wr=0; all done outputs 0; lb_data_out=0; if_data_out=0; cnt=0.
- Done pulses are exactly one cycle. Data outputs hold until the next done for that port.
- Grant edge G: mem_a shows byte 0 address from G.
- Write of N bytes: bytes written on edges G..G+N-1; done asserted from edge G+N.
- Read of N bytes: captures on edges G+1..G+N; done and data from edge G+N.
- Earliest next grant is edge G+N+1, giving one idle cycle between back-to-back transactions. In that idle cycle mem_wr=0 and mem_a=0.
- A requester must drop its en in the cycle done is seen. An en still high at edge G+N+1 is treated as a new request.
- rdy_in=0 freezes cnt and state. mem_wr is held, so the RAM sees a repeated write of the same byte, which is idempotent.

## Test plan
- Fetch only: if_addr_in=0x100, RAM bytes 13,05,00,00 -> mem_a steps 0x100..0x103; if_done_out pulses at G+4 with if_data_out=0x00000513.
- Store word: rob_addr_in=0x200, width 100, data 0xDEADBEEF -> mem_wr=1 for 4 cycles with bytes EF,BE,AD,DE at 0x200..0x203; rob_done_out at G+4.
- Priority: rob_en_in, lb_en_in and if_en_in all raised in the same cycle -> order STORE, LOAD, FETCH, each separated by one idle cycle.
- Flush mid-load: 4-byte load aborted by rob_rst_in after 2 captures -> no lb_done_out, mem_a=0, next grant goes to a pending store.
- IO stall: store SB to 0x30000 with io_buffer_full=1 for 5 cycles -> no mem_wr and no other grant; write occurs the edge after full drops; rob_done_out one cycle later.
- Async reset mid-write, plus a rdy_in=0 stall for 3 cycles mid-read -> outputs go 0 immediately on reset; the read completes with correct data and done delayed by 3 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single byte-wide RAM port between ROB stores, the load buffer
//   and instruction fetch. Fixed priority STORE > LOAD > FETCH, granted only
//   from IDLE. Each access is a byte-serial little-endian burst of 1, 2 or 4
//   bytes, finished by a one-cycle done pulse to the owner. A ROB flush
//   aborts an in-flight read; committed stores always complete.
//
// Ports
//   clk_in, rst_in (async, active-high), rdy_in (global enable / freeze)
//   rob_rst_in              : misprediction flush
//   rob_en/addr/width/data  : store request        -> rob_done_out
//   lb_en/addr/width        : load request         -> lb_done_out, lb_data_out
//   if_en/addr              : 4-byte fetch request -> if_done_out, if_data_out
//   mem_din/mem_dout/mem_a/mem_wr : RAM port (read data valid the cycle
//                                   after the address)
//   io_buffer_full          : UART full, stalls stores to addr[17:16]==2'b11
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rob_rst_in,
    input  logic                  rob_en_in,
    input  logic [ADDR_WIDTH-1:0] rob_addr_in,
    input  logic [2:0]            rob_width_in,
    input  logic [31:0]           rob_data_in,
    output logic                  rob_done_out,
    input  logic                  lb_en_in,
    input  logic [ADDR_WIDTH-1:0] lb_addr_in,
    input  logic [2:0]            lb_width_in,
    output logic                  lb_done_out,
    output logic [31:0]           lb_data_out,
    input  logic                  if_en_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    typedef enum logic [1:0] {STORE, LOAD, FETCH} owner_t;

    function automatic logic [2:0] width_bytes(input logic [2:0] w);
        case (w)
            3'b001:  return 3'd1;
            3'b010:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           buf_q, buf_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] mem_a_d;
    logic [7:0]            mem_dout_d;
    logic                  mem_wr_d;
    logic                  rob_done_d, lb_done_d, if_done_d;
    logic [31:0]           lb_data_d, if_data_d;

    logic                  last_byte;
    logic [1:0]            cnt_inc;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  store_stall;
    logic [31:0]           rd_word;

    // cnt is the index of the byte currently on the bus.
    assign last_byte   = ({1'b0, cnt_q} == (nbytes_q - 3'd1));
    assign cnt_inc     = cnt_q + 2'd1;
    assign next_addr   = addr_q + ADDR_WIDTH'(cnt_inc);
    assign store_stall = (rob_addr_in[17:16] == 2'b11) && io_buffer_full;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        data_d     = data_q;
        buf_d      = buf_q;
        nbytes_d   = nbytes_q;
        cnt_d      = cnt_q;
        mem_a_d    = mem_a;
        mem_dout_d = mem_dout;
        mem_wr_d   = mem_wr;
        rob_done_d = 1'b0;
        lb_done_d  = 1'b0;
        if_done_d  = 1'b0;
        lb_data_d  = lb_data_out;
        if_data_d  = if_data_out;

        // Buffer with the byte arriving this cycle merged in.
        rd_word = buf_q;
        rd_word[{cnt_q, 3'b000} +: 8] = mem_din;

        case (state_q)
            IDLE: begin
                mem_a_d  = '0;
                mem_wr_d = 1'b0;
                cnt_d    = 2'd0;
                if (rob_en_in) begin
                    // A stalled IO store blocks everything below it.
                    if (!store_stall) begin
                        state_d    = WRITE;
                        owner_d    = STORE;
                        addr_d     = rob_addr_in;
                        data_d     = rob_data_in;
                        nbytes_d   = width_bytes(rob_width_in);
                        mem_a_d    = rob_addr_in;
                        mem_dout_d = rob_data_in[7:0];
                        mem_wr_d   = 1'b1;
                    end
                end else if (!rob_rst_in && lb_en_in) begin
                    state_d  = READ;
                    owner_d  = LOAD;
                    addr_d   = lb_addr_in;
                    nbytes_d = width_bytes(lb_width_in);
                    buf_d    = '0;
                    mem_a_d  = lb_addr_in;
                end else if (!rob_rst_in && if_en_in) begin
                    state_d  = READ;
                    owner_d  = FETCH;
                    addr_d   = if_addr_in;
                    nbytes_d = 3'd4;
                    buf_d    = '0;
                    mem_a_d  = if_addr_in;
                end
            end

            WRITE: begin
                // Stores are committed, so a flush does not stop them.
                if (last_byte) begin
                    state_d    = IDLE;
                    mem_wr_d   = 1'b0;
                    mem_a_d    = '0;
                    rob_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_inc;
                    mem_a_d    = next_addr;
                    mem_dout_d = data_q[{cnt_inc, 3'b000} +: 8];
                end
            end

            READ: begin
                if (rob_rst_in) begin
                    state_d = IDLE;
                    mem_a_d = '0;
                end else begin
                    buf_d = rd_word;
                    if (last_byte) begin
                        state_d = IDLE;
                        mem_a_d = '0;
                        if (owner_q == LOAD) begin
                            lb_done_d = 1'b1;
                            lb_data_d = rd_word;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = rd_word;
                        end
                    end else begin
                        cnt_d   = cnt_inc;
                        mem_a_d = next_addr;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            owner_q      <= STORE;
            addr_q       <= '0;
            data_q       <= '0;
            buf_q        <= '0;
            nbytes_q     <= 3'd0;
            cnt_q        <= 2'd0;
            mem_a        <= '0;
            mem_dout     <= '0;
            mem_wr       <= 1'b0;
            rob_done_out <= 1'b0;
            lb_done_out  <= 1'b0;
            if_done_out  <= 1'b0;
            lb_data_out  <= '0;
            if_data_out  <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            buf_q        <= buf_d;
            nbytes_q     <= nbytes_d;
            cnt_q        <= cnt_d;
            mem_a        <= mem_a_d;
            mem_dout     <= mem_dout_d;
            mem_wr       <= mem_wr_d;
            rob_done_out <= rob_done_d;
            lb_done_out  <= lb_done_d;
            if_done_out  <= if_done_d;
            lb_data_out  <= lb_data_d;
            if_data_out  <= if_data_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A table of single transactions is
//   applied in a loop; hand-written sequences cover priority, flush, IO
//   stall, async reset and rdy_in freeze. Expected RAM writes and done
//   events are queued when stimulus is driven and popped by a monitor when
//   the DUT produces them.
module tb_mem_arbiter;

    localparam int AW = 32;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, rob_rst_in;
    logic          rob_en_in, lb_en_in, if_en_in;
    logic [AW-1:0] rob_addr_in, lb_addr_in, if_addr_in;
    logic [2:0]    rob_width_in, lb_width_in;
    logic [31:0]   rob_data_in;
    logic          rob_done_out, lb_done_out, if_done_out;
    logic [31:0]   lb_data_out, if_data_out;
    logic [7:0]    mem_din, mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;
    logic          io_buffer_full;

    mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_rst_in(rob_rst_in),
        .rob_en_in(rob_en_in), .rob_addr_in(rob_addr_in), .rob_width_in(rob_width_in),
        .rob_data_in(rob_data_in), .rob_done_out(rob_done_out),
        .lb_en_in(lb_en_in), .lb_addr_in(lb_addr_in), .lb_width_in(lb_width_in),
        .lb_done_out(lb_done_out), .lb_data_out(lb_data_out),
        .if_en_in(if_en_in), .if_addr_in(if_addr_in), .if_done_out(if_done_out),
        .if_data_out(if_data_out), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed { logic [31:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [1:0] port; logic [31:0] data; } done_t;   // port 0=rob 1=lb 2=if
    typedef struct {
        logic [1:0]  kind;        // 0 store, 1 load, 2 fetch
        logic [31:0] addr;
        logic [2:0]  width;
        logic [31:0] data;
        logic [31:0] exp_data;
        int          nbytes;
    } vec_t;

    logic [7:0] ram [0:1023];
    wr_t        wr_q[$];
    done_t      done_q[$];
    int         errors = 0;
    int         checks = 0;
    int         rob_cyc, lb_cyc, if_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RAM model and scoreboard monitor, all on the falling edge.
    always @(negedge clk_in) begin
        wr_t   w;
        done_t d;
        logic [1:0]  port;
        logic [31:0] got;
        if (!rst_in && rdy_in && mem_wr) begin
            ram[mem_a[9:0]] = mem_dout;
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%02h", mem_a, mem_dout);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", mem_a, w.addr);
                check("wr_data", {24'h0, mem_dout}, {24'h0, w.data});
            end
        end
        if (!rst_in && rdy_in && (rob_done_out || lb_done_out || if_done_out)) begin
            check("done_onehot", 32'(rob_done_out) + 32'(lb_done_out) + 32'(if_done_out), 32'd1);
            port = rob_done_out ? 2'd0 : (lb_done_out ? 2'd1 : 2'd2);
            got  = (port == 2'd1) ? lb_data_out : ((port == 2'd2) ? if_data_out : 32'h0);
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: port %0d data 0x%08h", port, got);
            end else begin
                d = done_q.pop_front();
                check("done_port", {30'h0, port}, {30'h0, d.port});
                check("done_data", got, d.data);
            end
        end
        mem_din = ram[mem_a[9:0]];
    end

    // Clock until every raised en has been answered, dropping each en in the
    // cycle its done is seen and recording that cycle.
    task automatic serve(input int budget);
        int cyc = 0;
        rob_cyc = 0; lb_cyc = 0; if_cyc = 0;
        while ((rob_en_in || lb_en_in || if_en_in) && cyc < budget) begin
            @(posedge clk_in); #1;
            cyc++;
            if (rob_done_out) begin rob_en_in = 1'b0; rob_cyc = cyc; end
            if (lb_done_out)  begin lb_en_in  = 1'b0; lb_cyc  = cyc; end
            if (if_done_out)  begin if_en_in  = 1'b0; if_cyc  = cyc; end
        end
        check("serve_timeout", {31'h0, rob_en_in | lb_en_in | if_en_in}, 32'h0);
        rob_en_in = 1'b0; lb_en_in = 1'b0; if_en_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        int   lat;
        vecs[0]  = '{2'd2, 32'h0000_0100, 3'b100, 32'h0,         32'h0000_0513, 4};
        vecs[1]  = '{2'd0, 32'h0000_0200, 3'b100, 32'hDEAD_BEEF, 32'h0,         4};
        vecs[2]  = '{2'd1, 32'h0000_0200, 3'b100, 32'h0,         32'hDEAD_BEEF, 4};
        vecs[3]  = '{2'd0, 32'h0000_0300, 3'b010, 32'h1234_ABCD, 32'h0,         2};
        vecs[4]  = '{2'd1, 32'h0000_0300, 3'b010, 32'h0,         32'h0000_ABCD, 2};
        vecs[5]  = '{2'd1, 32'h0000_0201, 3'b001, 32'h0,         32'h0000_00BE, 1};
        vecs[6]  = '{2'd0, 32'h0000_0204, 3'b001, 32'hFFFF_FF80, 32'h0,         1};
        vecs[7]  = '{2'd1, 32'h0000_0202, 3'b100, 32'h0,         32'h0080_DEAD, 4};
        vecs[8]  = '{2'd0, 32'hFFFF_FFFE, 3'b111, 32'h0A0B_0C0D, 32'h0,         4};
        vecs[9]  = '{2'd1, 32'hFFFF_FFFE, 3'b000, 32'h0,         32'h0A0B_0C0D, 4};
        vecs[10] = '{2'd1, 32'h0000_0300, 3'b100, 32'h0,         32'h0000_ABCD, 4};
        vecs[11] = '{2'd2, 32'h0000_0200, 3'b100, 32'h0,         32'hDEAD_BEEF, 4};

        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h05;

        rst_in = 1'b1; rdy_in = 1'b1; rob_rst_in = 1'b0; io_buffer_full = 1'b0;
        rob_en_in = 1'b0; lb_en_in = 1'b0; if_en_in = 1'b0;
        rob_addr_in = '0; lb_addr_in = '0; if_addr_in = '0;
        rob_width_in = '0; lb_width_in = '0; rob_data_in = '0;

        // Reset state
        #1;
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
        check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        check("rst_dones", {29'h0, rob_done_out, lb_done_out, if_done_out}, 32'h0);
        check("rst_lb_data", lb_data_out, 32'h0);
        check("rst_if_data", if_data_out, 32'h0);
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Table of single transactions
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_in); #1;
            case (vecs[i].kind)
                2'd0: begin
                    rob_en_in = 1'b1; rob_addr_in = vecs[i].addr;
                    rob_width_in = vecs[i].width; rob_data_in = vecs[i].data;
                    for (int b = 0; b < vecs[i].nbytes; b++)
                        wr_q.push_back('{vecs[i].addr + 32'(b), vecs[i].data[8*b +: 8]});
                    done_q.push_back('{2'd0, 32'h0});
                end
                2'd1: begin
                    lb_en_in = 1'b1; lb_addr_in = vecs[i].addr; lb_width_in = vecs[i].width;
                    done_q.push_back('{2'd1, vecs[i].exp_data});
                end
                default: begin
                    if_en_in = 1'b1; if_addr_in = vecs[i].addr;
                    done_q.push_back('{2'd2, vecs[i].exp_data});
                end
            endcase
            serve(40);
            lat = (vecs[i].kind == 2'd0) ? rob_cyc : ((vecs[i].kind == 2'd1) ? lb_cyc : if_cyc);
            check($sformatf("latency_%0d", i), lat, vecs[i].nbytes + 1);
            check($sformatf("idle_mem_a_%0d", i), mem_a, 32'h0);
            check($sformatf("idle_mem_wr_%0d", i), {31'h0, mem_wr}, 32'h0);
        end

        // Priority: all three requests raised together
        @(posedge clk_in); #1;
        rob_en_in = 1'b1; rob_addr_in = 32'h208; rob_width_in = 3'b001; rob_data_in = 32'h11;
        lb_en_in = 1'b1; lb_addr_in = 32'h300; lb_width_in = 3'b010;
        if_en_in = 1'b1; if_addr_in = 32'h100;
        wr_q.push_back('{32'h208, 8'h11});
        done_q.push_back('{2'd0, 32'h0});
        done_q.push_back('{2'd1, 32'h0000_ABCD});
        done_q.push_back('{2'd2, 32'h0000_0513});
        serve(40);
        check("prio_store_cyc", rob_cyc, 2);
        check("prio_load_cyc", lb_cyc, 5);
        check("prio_fetch_cyc", if_cyc, 10);
        check("lb_data_held", lb_data_out, 32'h0000_ABCD);

        // Flush mid-load, pending store granted next
        @(posedge clk_in); #1;
        lb_en_in = 1'b1; lb_addr_in = 32'h100; lb_width_in = 3'b100;
        @(posedge clk_in); #1;
        check("flush_grant_a", mem_a, 32'h100);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        check("flush_pre_a", mem_a, 32'h102);
        rob_rst_in = 1'b1;
        rob_en_in = 1'b1; rob_addr_in = 32'h210; rob_width_in = 3'b001; rob_data_in = 32'h77;
        wr_q.push_back('{32'h210, 8'h77});
        done_q.push_back('{2'd0, 32'h0});
        @(posedge clk_in); #1;
        check("flush_mem_a", mem_a, 32'h0);
        check("flush_no_lb_done", {31'h0, lb_done_out}, 32'h0);
        check("flush_no_wr", {31'h0, mem_wr}, 32'h0);
        rob_rst_in = 1'b0; lb_en_in = 1'b0;
        @(posedge clk_in); #1;
        check("flush_store_wr", {31'h0, mem_wr}, 32'h1);
        check("flush_store_a", mem_a, 32'h210);
        serve(10);
        check("flush_store_done", rob_cyc, 1);

        // Flush in IDLE blocks a load grant
        @(posedge clk_in); #1;
        lb_en_in = 1'b1; lb_addr_in = 32'h100; lb_width_in = 3'b001; rob_rst_in = 1'b1;
        @(posedge clk_in); #1;
        check("flush_blocks_load", mem_a, 32'h0);
        rob_rst_in = 1'b0;
        done_q.push_back('{2'd1, 32'h0000_0013});
        serve(10);
        check("after_flush_load_cyc", lb_cyc, 2);

        // IO stall: store to 0x30000 while the UART buffer is full
        @(posedge clk_in); #1;
        io_buffer_full = 1'b1;
        rob_en_in = 1'b1; rob_addr_in = 32'h3_0000; rob_width_in = 3'b001; rob_data_in = 32'h5A;
        lb_en_in = 1'b1; lb_addr_in = 32'h300; lb_width_in = 3'b001;
        wr_q.push_back('{32'h3_0000, 8'h5A});
        done_q.push_back('{2'd0, 32'h0});
        done_q.push_back('{2'd1, 32'h0000_00CD});
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_in); #1;
            check($sformatf("io_stall_wr_%0d", k), {31'h0, mem_wr}, 32'h0);
            check($sformatf("io_stall_a_%0d", k), mem_a, 32'h0);
        end
        io_buffer_full = 1'b0;
        @(posedge clk_in); #1;
        check("io_write_edge", {31'h0, mem_wr}, 32'h1);
        check("io_write_a", mem_a, 32'h3_0000);
        serve(20);
        check("io_store_done", rob_cyc, 1);
        check("io_load_after", lb_cyc, 3);

        // Async reset in the middle of a word store
        @(posedge clk_in); #1;
        rob_en_in = 1'b1; rob_addr_in = 32'h220; rob_width_in = 3'b100; rob_data_in = 32'hCAFE_F00D;
        wr_q.push_back('{32'h220, 8'h0D});
        wr_q.push_back('{32'h221, 8'hF0});
        @(posedge clk_in);
        @(posedge clk_in);
        @(posedge clk_in); #3;
        rst_in = 1'b1;
        #1;
        check("arst_mem_wr", {31'h0, mem_wr}, 32'h0);
        check("arst_mem_a", mem_a, 32'h0);
        check("arst_mem_dout", {24'h0, mem_dout}, 32'h0);
        check("arst_lb_data", lb_data_out, 32'h0);
        check("arst_if_data", if_data_out, 32'h0);
        rob_en_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // rdy_in low for 3 cycles in the middle of a fetch
        @(posedge clk_in); #1;
        if_en_in = 1'b1; if_addr_in = 32'h100;
        done_q.push_back('{2'd2, 32'h0000_0513});
        begin
            int cyc = 0;
            if_cyc = 0;
            while (if_en_in && cyc < 30) begin
                @(posedge clk_in); #1;
                cyc++;
                if (cyc == 2) rdy_in = 1'b0;
                if (cyc == 5) rdy_in = 1'b1;
                if (if_done_out) begin if_en_in = 1'b0; if_cyc = cyc; end
            end
            rdy_in = 1'b1; if_en_in = 1'b0;
        end
        check("rdy_stall_done_cyc", if_cyc, 8);
        check("rdy_stall_data", if_data_out, 32'h0000_0513);

        repeat (3) @(posedge clk_in);
        #1;
        check("wr_q_drained", wr_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
